// File: rtl/fetch_pkg.sv
// ============================================================================
//  Package  : fetch_pkg
//  Purpose  : Shared defaults and the instruction-pair record used by the
//             dual-issue fetch stage and its pair buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    // One fetched pair as delivered to decode.
    typedef struct packed {
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic [31:0] instr1;
        logic [31:0] instr2;
    } fetch_pair_t;

    // Redirect targets are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pair_fifo.sv
// ============================================================================
//  Module   : fetch_pair_fifo
//  Purpose  : Small synchronous FIFO of fetch pairs with synchronous clear,
//             occupancy count and fall-through when empty (a pair pushed into
//             an empty buffer is visible at the head in the same cycle).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_pair_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  fetch_pair_t              wdata,
    input  logic                     pop,
    output logic                     valid,
    output fetch_pair_t              head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    fetch_pair_t         mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         cnt;
    logic                empty;
    logic                bypass;
    logic                do_push;
    logic                do_pop;

    // Fall-through control: an empty buffer presents the incoming pair directly,
    // and if decode takes it in the same cycle it is never stored.
    always_comb begin
        empty   = (cnt == '0);
        bypass  = empty && push;
        do_push = push && !(bypass && pop);
        do_pop  = pop && !empty;
        valid   = !empty || push;
        head    = bypass ? wdata : mem[rd_ptr];
        count   = cnt;
    end

    // Storage, pointers and occupancy; clear empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

`default_nettype wire

// File: rtl/dual_fetch_unit.sv
// ============================================================================
//  Module   : dual_fetch_unit
//  Purpose  : Dual-issue fetch stage. Issues PC pairs to a 1-cycle synchronous
//             instruction memory under a credit rule, buffers returned pairs
//             and hands them to decode over valid/ready. Execute-stage branch
//             resolution redirects fetch and flushes buffered work.
//  Options  : FETCH_PERF_CNT_EN adds saturating perf_redirects and
//             perf_stall_cycles counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dual_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          PC_STEP    = DEFAULT_PC_STEP,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr1,
    output logic [31:0] imem_addr2,
    input  logic [31:0] imem_rdata1,
    input  logic [31:0] imem_rdata2,
    input  logic        isBranchTaken1,
    input  logic [31:0] branchPC1,
    input  logic        isBranchTaken2,
    input  logic [31:0] branchPC2,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] pc1,
    output logic [31:0] pc2,
    output logic [31:0] instr1,
    output logic [31:0] instr2,
    output logic        flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int          CW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] STEP      = 32'(PC_STEP);
    localparam logic [31:0] PAIR_STEP = 32'(2 * PC_STEP);

    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic         inflight;
    logic         redirect;
    logic [31:0]  target;
    logic         issue;
    logic [CW:0]  fifo_count;
    logic [CW:0]  credit_used;
    logic         fifo_valid;
    logic         push;
    logic         pop;
    fetch_pair_t  push_pair;
    fetch_pair_t  head_pair;

    // Redirect mux (older lane wins), credit-based issue and decode handshake.
    always_comb begin
        redirect    = isBranchTaken1 | isBranchTaken2;
        target      = word_align(isBranchTaken1 ? branchPC1 : branchPC2);
        credit_used = fifo_count + {{CW{1'b0}}, inflight};
        issue       = rst_n && !redirect && (credit_used < (CW + 1)'(FIFO_DEPTH));
        push        = inflight && !redirect;
        push_pair   = '{pc1: req_pc, pc2: req_pc + STEP,
                        instr1: imem_rdata1, instr2: imem_rdata2};
        dec_valid   = fifo_valid && !redirect;
        pop         = dec_valid && dec_ready;
        flush       = redirect;
        imem_req    = issue;
        imem_addr1  = fetch_pc;
        imem_addr2  = fetch_pc + STEP;
        pc1         = head_pair.pc1;
        pc2         = head_pair.pc2;
        instr1      = head_pair.instr1;
        instr2      = head_pair.instr2;
    end

    // Fetch PC, address of the outstanding request and the in-flight flag;
    // a redirect squashes the outstanding response and restarts at the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PAIR_STEP;
            end
        end
    end

    fetch_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (push),
        .wdata (push_pair),
        .pop   (pop),
        .valid (fifo_valid),
        .head  (head_pair),
        .count (fifo_count)
    );

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters for redirects and decode back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (redirect && (perf_redirects != '1)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if (dec_valid && !dec_ready && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_fetch_unit.sv
// ============================================================================
//  Module   : tb_dual_fetch_unit
//  Purpose  : Self-checking bench for dual_fetch_unit: instruction memory
//             model, stream-level reference model, directed and random phases.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dual_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr1, imem_addr2;
    logic [31:0] imem_rdata1, imem_rdata2;
    logic        tk1, tk2;
    logic [31:0] bpc1, bpc2;
    logic        dec_valid, dec_ready;
    logic [31:0] pc1, pc2, instr1, instr2;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_redirects, perf_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    dual_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .PC_STEP    (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr1     (imem_addr1),
        .imem_addr2     (imem_addr2),
        .imem_rdata1    (imem_rdata1),
        .imem_rdata2    (imem_rdata2),
        .isBranchTaken1 (tk1),
        .branchPC1      (bpc1),
        .isBranchTaken2 (tk2),
        .branchPC2      (bpc2),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .pc1            (pc1),
        .pc2            (pc2),
        .instr1         (instr1),
        .instr2         (instr2),
        .flush          (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Instruction content is a fixed function of the address, distinct from it.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: request sampled mid-cycle, data returned after the edge;
    // garbage is returned when no request was made.
    logic        lat_req;
    logic [31:0] lat_a1, lat_a2;
    always @(negedge clk) begin
        lat_req = imem_req;
        lat_a1  = imem_addr1;
        lat_a2  = imem_addr2;
    end
    always @(posedge clk) begin
        if (lat_req) begin
            imem_rdata1 <= mem_word(lat_a1);
            imem_rdata2 <= mem_word(lat_a2);
        end else begin
            imem_rdata1 <= $urandom;
            imem_rdata2 <= $urandom;
        end
    end

    // Stream-level reference: fetch requests and decoded pairs each form a
    // contiguous +8 address stream restarted by every redirect, and the number
    // of requested-but-undelivered pairs never exceeds the buffer depth.
    logic [31:0] m_fetch, m_dec;
    int          outstanding;
    logic        hold_prev;
    logic [31:0] m_perf_red, m_perf_stall;

    always @(negedge clk) begin
        logic        red;
        logic [31:0] tgt;
        if (!rst_n) begin
            check("rst_req", {31'b0, imem_req}, 32'd0);
            check("rst_valid", {31'b0, dec_valid}, 32'd0);
            check("rst_flush", {31'b0, flush}, 32'd0);
            check("rst_pc1", pc1, 32'd0);
            check("rst_instr2", instr2, 32'd0);
            m_fetch      = RESET_PC;
            m_dec        = RESET_PC;
            outstanding  = 0;
            hold_prev    = 1'b0;
            m_perf_red   = 0;
            m_perf_stall = 0;
        end else begin
            red = tk1 | tk2;
            tgt = (tk1 ? bpc1 : bpc2) & 32'hFFFF_FFFC;
`ifdef FETCH_PERF_CNT_EN
            check("perf_redirects", perf_redirects, m_perf_red);
            check("perf_stall", perf_stall_cycles, m_perf_stall);
`endif
            check("flush", {31'b0, flush}, {31'b0, red});
            if (red) begin
                check("redir_valid", {31'b0, dec_valid}, 32'd0);
                check("redir_req", {31'b0, imem_req}, 32'd0);
                m_fetch     = tgt;
                m_dec       = tgt;
                outstanding = 0;
            end else begin
                if (imem_req) begin
                    check("req_addr1", imem_addr1, m_fetch);
                    check("req_addr2", imem_addr2, m_fetch + 32'd4);
                    m_fetch     = m_fetch + 32'd8;
                    outstanding = outstanding + 1;
                end
                if (hold_prev) check("stall_hold", {31'b0, dec_valid}, 32'd1);
                if (dec_valid) begin
                    check("pc1", pc1, m_dec);
                    check("pc2", pc2, m_dec + 32'd4);
                    check("instr1", instr1, mem_word(m_dec));
                    check("instr2", instr2, mem_word(m_dec + 32'd4));
                    if (dec_ready) begin
                        m_dec       = m_dec + 32'd8;
                        outstanding = outstanding - 1;
                    end
                end
                check("credit", {31'b0, (outstanding <= DEPTH)}, 32'd1);
            end
            hold_prev = !red && dec_valid && !dec_ready;
            if (red) m_perf_red = m_perf_red + 1;
            if (dec_valid && !dec_ready) m_perf_stall = m_perf_stall + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Redirect in cycle N, then expect fetch at the target in N+1 and the
    // target pair at the decode head in N+2.
    task automatic do_redirect(input logic t1, input logic [31:0] p1,
                               input logic t2, input logic [31:0] p2,
                               input logic [31:0] exp);
        next_cycle();
        tk1 = t1; bpc1 = p1; tk2 = t2; bpc2 = p2;
        @(negedge clk);
        check("dir_flush", {31'b0, flush}, 32'd1);
        check("dir_valid_n", {31'b0, dec_valid}, 32'd0);
        next_cycle();
        tk1 = 1'b0; tk2 = 1'b0;
        @(negedge clk);
        check("dir_req_n1", {31'b0, imem_req}, 32'd1);
        check("dir_addr_n1", imem_addr1, exp);
        @(negedge clk);
        check("dir_valid_n2", {31'b0, dec_valid}, 32'd1);
        check("dir_pc1_n2", pc1, exp);
        check("dir_pc2_n2", pc2, exp + 32'd4);
    endtask

    initial begin
        logic [31:0] exp_seq [3];
        logic        exp_req [5];
        exp_seq = '{32'h0, 32'h8, 32'h10};
        exp_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        rst_n = 1'b0; dec_ready = 1'b1;
        tk1 = 1'b0; tk2 = 1'b0; bpc1 = '0; bpc2 = '0;
        repeat (3) next_cycle();

        // Streaming from reset.
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_req0", {31'b0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr1, 32'h0);
        check("t1_valid0", {31'b0, dec_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_valid", {31'b0, dec_valid}, 32'd1);
            check("t1_pc1", pc1, exp_seq[i]);
            check("t1_pc2", pc2, exp_seq[i] + 32'd4);
        end
        check("t1_instr2_lit", instr2, 32'hDEAD_0014);
        repeat (8) next_cycle();

        // Back-pressure from reset: two pairs buffered, then fetch stops.
        rst_n = 1'b0; dec_ready = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_req", {31'b0, imem_req}, {31'b0, exp_req[i]});
        end
        check("t2_head", pc1, 32'h0);
        check("t2_valid", {31'b0, dec_valid}, 32'd1);
        next_cycle();
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_order", pc1, exp_seq[i]);
        end

        // Directed redirects, alignment, priority and wrap-around.
        do_redirect(1'b0, 32'h0, 1'b1, 32'h100, 32'h100);
        do_redirect(1'b1, 32'h40, 1'b1, 32'h80, 32'h40);
        do_redirect(1'b1, 32'h43, 1'b0, 32'h99, 32'h40);
        do_redirect(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'hFFFF_FFF8);
        @(negedge clk);
        check("t5_wrap_pc1", pc1, 32'h0);
        check("t5_wrap_pc2", pc2, 32'h4);

        // Randomized traffic, back-pressure and redirects.
        for (int c = 0; c < 800; c++) begin
            int r;
            next_cycle();
            dec_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 99);
            tk1 = 1'b0; tk2 = 1'b0;
            bpc1 = $urandom; bpc2 = $urandom;
            if (r < 5) begin
                tk1 = 1'b1; tk2 = $urandom_range(0, 1) == 1;
            end else if (r < 9) begin
                tk2 = 1'b1;
            end
        end
        next_cycle();
        tk1 = 1'b0; tk2 = 1'b0; dec_ready = 1'b1;
        repeat (5) next_cycle();

        // Reset while a response is in flight.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_valid", {31'b0, dec_valid}, 32'd0);
        check("t6_req", {31'b0, imem_req}, 32'd0);
        check("t6_pc1", pc1, 32'd0);
        check("t6_instr1", instr1, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t6_perf_red", perf_redirects, 32'd0);
        check("t6_perf_stall", perf_stall_cycles, 32'd0);
`endif
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_restart_addr", imem_addr1, RESET_PC);
        @(negedge clk);
        check("t6_restart_pc1", pc1, RESET_PC);
        check("t6_restart_instr1", instr1, 32'hDEAD_0000);
        repeat (4) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
